// File: rtl/uart_responder_pkg.sv
// rtl/uart_responder_pkg.sv - shared types and state encodings for the UART responder
package uart_responder_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_responder_if.sv
// rtl/uart_responder_if.sv - CPU-side strobe/byte bus between initiator and UART responder
interface uart_responder_if;

    logic                           wrn;
    logic                           rdn;
    uart_responder_pkg::uart_byte_t data_in;
    uart_responder_pkg::uart_byte_t data_out;
    logic                           data_ready;
    logic                           tbre;
    logic                           tsre;
    logic                           rx_overrun;
    logic                           rx_frame_err;

    modport master (
        output wrn, rdn, data_in,
        input  data_out, data_ready, tbre, tsre, rx_overrun, rx_frame_err
    );

    modport slave (
        input  wrn, rdn, data_in,
        output data_out, data_ready, tbre, tsre, rx_overrun, rx_frame_err
    );

endinterface

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - rxd synchronizer, start/data/stop sampling and bit timer
module uart_rx_fsm
    import uart_responder_pkg::*;
#(
    parameter int CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       byte_valid,
    output uart_byte_t rx_byte,
    output logic       frame_err
);

    localparam int              TW        = $clog2(CLK_DIV) + 1;
    localparam logic [TW-1:0]   BIT_LAST  = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0]   HALF_LAST = TW'(CLK_DIV / 2 - 1);

    rx_state_t     state, state_next;
    logic          sync1, sync2, rxd_q;
    logic [TW-1:0] timer;
    logic [2:0]    bit_cnt;
    uart_byte_t    shreg;
    logic          tick;
    logic          fall;

    assign fall       = rxd_q & ~sync2;
    assign byte_valid = (state == RX_STOP) && tick;
    assign rx_byte    = shreg;
    assign frame_err  = ~sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RX_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        tick       = 1'b0;
        case (state)
            RX_IDLE:  if (fall) state_next = RX_START;
            RX_START: if (timer == HALF_LAST) begin
                tick       = 1'b1;
                // a line back high at mid-start was a glitch, not a frame
                state_next = sync2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA:  if (timer == BIT_LAST) begin
                tick = 1'b1;
                if (bit_cnt == 3'd7) state_next = RX_STOP;
            end
            RX_STOP:  if (timer == BIT_LAST) begin
                tick       = 1'b1;
                state_next = RX_IDLE;
            end
            default:  state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rxd_q   <= 1'b1;
            timer   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
            rxd_q <= sync2;
            timer <= (state == RX_IDLE || tick) ? '0 : timer + 1'b1;
            if (state == RX_DATA && tick) begin
                shreg   <= {sync2, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/uart_responder.sv
// rtl/uart_responder.sv - strobe-driven UART device: THR/TX FSM, RBR and status flags
module uart_responder
    import uart_responder_pkg::*;
#(
    parameter int CLK_DIV = 434
) (
    input  logic             clk,
    input  logic             rst,
    uart_responder_if.slave  bus,
    input  logic             rxd,
    output logic             txd
);

    localparam int            TW       = $clog2(CLK_DIV) + 1;
    localparam logic [TW-1:0] BIT_LAST = TW'(CLK_DIV - 1);

    logic          wrn_q, rdn_q, wr_edge, rd_edge;
    uart_byte_t    thr, shifter, rbr;
    logic          tbre_r, tsre_r, data_ready_r, overrun_r, frame_err_r;
    tx_state_t     tx_state, tx_next;
    logic [TW-1:0] tx_timer;
    logic [2:0]    tx_bits;
    logic          tx_tick, tx_load;
    logic          rx_valid, rx_ferr;
    uart_byte_t    rx_byte;

    assign wr_edge = ~wrn_q & bus.wrn;
    assign rd_edge = ~rdn_q & bus.rdn;

    assign bus.data_out     = rbr;
    assign bus.data_ready   = data_ready_r;
    assign bus.tbre         = tbre_r;
    assign bus.tsre         = tsre_r;
    assign bus.rx_overrun   = overrun_r;
    assign bus.rx_frame_err = frame_err_r;

    uart_rx_fsm #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .byte_valid (rx_valid),
        .rx_byte    (rx_byte),
        .frame_err  (rx_ferr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        tx_load = 1'b0;
        tx_tick = (tx_state != TX_IDLE) && (tx_timer == BIT_LAST);
        case (tx_state)
            TX_IDLE:  if (!tbre_r) begin
                tx_load = 1'b1;
                tx_next = TX_START;
            end
            TX_START: if (tx_tick) tx_next = TX_DATA;
            TX_DATA:  if (tx_tick && tx_bits == 3'd7) tx_next = TX_STOP;
            TX_STOP:  if (tx_tick) begin
                // a full THR chains straight into the next start bit
                if (!tbre_r) begin
                    tx_load = 1'b1;
                    tx_next = TX_START;
                end else begin
                    tx_next = TX_IDLE;
                end
            end
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrn_q    <= 1'b1;
            thr      <= '0;
            shifter  <= '0;
            tbre_r   <= 1'b1;
            tsre_r   <= 1'b1;
            txd      <= 1'b1;
            tx_timer <= '0;
            tx_bits  <= '0;
        end else begin
            wrn_q <= bus.wrn;
            if (wr_edge && tbre_r) begin
                thr    <= bus.data_in;
                tbre_r <= 1'b0;
            end
            if (tx_load) begin
                shifter  <= thr;
                tbre_r   <= 1'b1;
                tsre_r   <= 1'b0;
                txd      <= 1'b0;
                tx_timer <= '0;
                tx_bits  <= '0;
            end else if (tx_tick) begin
                tx_timer <= '0;
                case (tx_state)
                    TX_START: txd <= shifter[0];
                    TX_DATA: begin
                        shifter <= shifter >> 1;
                        txd     <= (tx_bits == 3'd7) ? 1'b1 : shifter[1];
                        tx_bits <= tx_bits + 3'd1;
                    end
                    TX_STOP:  tsre_r <= 1'b1;
                    default:  txd <= 1'b1;
                endcase
            end else if (tx_state != TX_IDLE) begin
                tx_timer <= tx_timer + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdn_q        <= 1'b1;
            rbr          <= '0;
            data_ready_r <= 1'b0;
            overrun_r    <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            rdn_q       <= bus.rdn;
            frame_err_r <= rx_valid && rx_ferr;
            // a completing good byte wins over a simultaneous read
            if (rx_valid && !rx_ferr) begin
                if (data_ready_r && !rd_edge) begin
                    overrun_r <= 1'b1;
                end else begin
                    rbr          <= rx_byte;
                    data_ready_r <= 1'b1;
                    if (rd_edge) overrun_r <= 1'b0;
                end
            end else if (rd_edge) begin
                data_ready_r <= 1'b0;
                overrun_r    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_responder.sv
// tb/tb_uart_responder.sv - directed self-checking bench for uart_responder at CLK_DIV=8
module tb_uart_responder;

    localparam int CD     = 8;
    localparam int RX_LAT = 79;  // 8/2 + 9*8 + 3

    logic clk = 1'b0;
    logic rst;
    logic rxd;
    logic txd;
    int   errors = 0;
    int   checks = 0;

    uart_responder_if bus ();

    uart_responder #(.CLK_DIV(CD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .rxd (rxd),
        .txd (txd)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus.data_in = b;
        bus.wrn = 1'b0;
        tick(1);
        bus.wrn = 1'b1;
        tick(1);
    endtask

    task automatic read_pulse();
        bus.rdn = 1'b0;
        tick(1);
        bus.rdn = 1'b1;
        tick(1);
    endtask

    task automatic capture_tx(output logic [9:0] bits, output int tsre_low);
        bits = '0;
        tsre_low = 0;
        for (int c = 0; c < 10 * CD; c++) begin
            if (bus.tsre == 1'b0) tsre_low++;
            if (c % CD == CD / 2) bits[c / CD] = txd;
            tick(1);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int rd_at,
                           output int ready_cyc, output int fe_cnt);
        logic [9:0] frame;
        logic       prev;
        frame     = {stop, b, 1'b0};
        prev      = bus.data_ready;
        ready_cyc = -1;
        fe_cnt    = 0;
        for (int c = 0; c < 10 * CD; c++) begin
            if (bus.data_ready && !prev && ready_cyc < 0) ready_cyc = c;
            prev = bus.data_ready;
            if (bus.rx_frame_err) fe_cnt++;
            rxd = frame[c / CD];
            if (c == rd_at - 2) bus.rdn = 1'b0;
            if (c == rd_at - 1) bus.rdn = 1'b1;
            tick(1);
        end
        rxd = 1'b1;
    endtask

    task automatic test_reset();
        logic [5:0] flags;
        rst = 1'b1;
        bus.wrn = 1'b1;
        bus.rdn = 1'b1;
        bus.data_in = 8'h00;
        rxd = 1'b1;
        tick(2);
        flags = {txd, bus.tbre, bus.tsre, bus.data_ready, bus.rx_overrun, bus.rx_frame_err};
        checks++;
        if (flags !== 6'b111000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected %b", flags, 6'b111000);
        end
        checks++;
        if (bus.data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_data_out: got %h expected 00", bus.data_out);
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_single_tx();
        logic [9:0] bits;
        int         low;
        write_byte(8'hA5);
        checks++;
        if (bus.tbre !== 1'b0) begin
            errors++;
            $display("FAIL tx_tbre_load: got %b expected 0", bus.tbre);
        end
        tick(1);
        checks++;
        if ({bus.tbre, bus.tsre, txd} !== 3'b100) begin
            errors++;
            $display("FAIL tx_start: got %b expected 100", {bus.tbre, bus.tsre, txd});
        end
        capture_tx(bits, low);
        checks++;
        if (bits !== 10'b1101001010) begin
            errors++;
            $display("FAIL tx_frame_a5: got %b expected 1101001010", bits);
        end
        checks++;
        if (low !== 80 || bus.tsre !== 1'b1 || txd !== 1'b1) begin
            errors++;
            $display("FAIL tx_tsre_len: got low=%0d tsre=%b txd=%b expected 80 1 1", low, bus.tsre, txd);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] bits;
        int          low;
        write_byte(8'h55);
        tick(1);
        checks++;
        if (bus.tbre !== 1'b1) begin
            errors++;
            $display("FAIL b2b_tbre: got %b expected 1", bus.tbre);
        end
        bits = '0;
        low = 0;
        for (int c = 0; c < 20 * CD; c++) begin
            if (bus.tsre == 1'b0) low++;
            if (c % CD == CD / 2) bits[c / CD] = txd;
            if (c == 2 || c == 4) begin
                checks++;
                if (bus.tbre !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_thr_full_c%0d: got %b expected 0", c, bus.tbre);
                end
            end
            case (c)
                0: begin bus.data_in = 8'h0F; bus.wrn = 1'b0; end
                1: bus.wrn = 1'b1;
                2: begin bus.data_in = 8'hFF; bus.wrn = 1'b0; end
                3: bus.wrn = 1'b1;
                default: ;
            endcase
            tick(1);
        end
        checks++;
        if (bits !== 20'b1000011110_1010101010) begin
            errors++;
            $display("FAIL b2b_frames: got %b expected %b", bits, 20'b1000011110_1010101010);
        end
        checks++;
        if (low !== 160 || bus.tsre !== 1'b1 || bus.tbre !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_gap: got low=%0d tsre=%b tbre=%b expected 160 1 1", low, bus.tsre, bus.tbre);
        end
    endtask

    task automatic test_rx_good();
        int rc, fe;
        send_rx(8'h3C, 1'b1, -100, rc, fe);
        checks++;
        if (rc !== RX_LAT || bus.data_out !== 8'h3C || fe !== 0) begin
            errors++;
            $display("FAIL rx_good: got lat=%0d data=%h fe=%0d expected %0d 3c 0", rc, bus.data_out, fe, RX_LAT);
        end
        read_pulse();
        checks++;
        if (bus.data_ready !== 1'b0 || bus.data_out !== 8'h3C) begin
            errors++;
            $display("FAIL rx_read: got ready=%b data=%h expected 0 3c", bus.data_ready, bus.data_out);
        end
    endtask

    task automatic test_overrun_frame();
        int rc, fe;
        send_rx(8'h11, 1'b1, -100, rc, fe);
        tick(3);
        send_rx(8'h22, 1'b1, -100, rc, fe);
        tick(2);
        checks++;
        if ({bus.data_ready, bus.rx_overrun} !== 2'b11 || bus.data_out !== 8'h11) begin
            errors++;
            $display("FAIL rx_overrun: got ready=%b ovr=%b data=%h expected 1 1 11",
                     bus.data_ready, bus.rx_overrun, bus.data_out);
        end
        read_pulse();
        checks++;
        if ({bus.data_ready, bus.rx_overrun} !== 2'b00) begin
            errors++;
            $display("FAIL rx_overrun_clear: got %b expected 00", {bus.data_ready, bus.rx_overrun});
        end
        send_rx(8'h33, 1'b0, -100, rc, fe);
        tick(3);
        checks++;
        if (fe !== 1 || bus.data_ready !== 1'b0 || bus.data_out !== 8'h11 || bus.rx_frame_err !== 1'b0) begin
            errors++;
            $display("FAIL rx_frame_err: got pulses=%0d ready=%b data=%h expected 1 0 11",
                     fe, bus.data_ready, bus.data_out);
        end
    endtask

    task automatic test_corners();
        int rc, fe, ready_seen;
        rxd = 1'b0;
        tick(2);
        rxd = 1'b1;
        fe = 0;
        ready_seen = 0;
        for (int c = 0; c < 100; c++) begin
            if (bus.rx_frame_err) fe++;
            if (bus.data_ready) ready_seen++;
            tick(1);
        end
        checks++;
        if (fe !== 0 || ready_seen !== 0) begin
            errors++;
            $display("FAIL rx_glitch: got fe=%0d ready_cycles=%0d expected 0 0", fe, ready_seen);
        end
        send_rx(8'h7E, 1'b1, -100, rc, fe);
        tick(3);
        send_rx(8'h44, 1'b1, RX_LAT, rc, fe);
        tick(2);
        checks++;
        if (bus.data_ready !== 1'b1 || bus.data_out !== 8'h44 || bus.rx_overrun !== 1'b0) begin
            errors++;
            $display("FAIL rx_rdn_collision: got ready=%b data=%h ovr=%b expected 1 44 0",
                     bus.data_ready, bus.data_out, bus.rx_overrun);
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] frame;
        logic [9:0] bits;
        logic [4:0] flags;
        int         low, rc, fe;
        frame = {1'b1, 8'h5A, 1'b0};
        for (int c = 0; c < 50; c++) begin
            rxd = frame[c / CD];
            if (c == 12) begin bus.data_in = 8'h81; bus.wrn = 1'b0; end
            if (c == 13) bus.wrn = 1'b1;
            tick(1);
        end
        checks++;
        if (bus.tsre !== 1'b0 || bus.data_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: got tsre=%b ready=%b expected 0 1", bus.tsre, bus.data_ready);
        end
        rst = 1'b1;
        #1;
        flags = {txd, bus.tbre, bus.tsre, bus.data_ready, bus.rx_overrun};
        checks++;
        if (flags !== 5'b11100 || bus.data_out !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: got flags=%b data=%h expected 11100 00", flags, bus.data_out);
        end
        rxd = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        write_byte(8'hC3);
        tick(1);
        capture_tx(bits, low);
        checks++;
        if (bits !== 10'b1110000110 || low !== 80) begin
            errors++;
            $display("FAIL post_reset_tx: got %b low=%0d expected 1110000110 80", bits, low);
        end
        send_rx(8'h96, 1'b1, -100, rc, fe);
        checks++;
        if (rc !== RX_LAT || bus.data_out !== 8'h96) begin
            errors++;
            $display("FAIL post_reset_rx: got lat=%0d data=%h expected %0d 96", rc, bus.data_out, RX_LAT);
        end
    endtask

    initial begin
        test_reset();
        test_single_tx();
        tick(5);
        test_back_to_back();
        tick(5);
        test_rx_good();
        tick(5);
        test_overrun_frame();
        tick(5);
        test_corners();
        tick(5);
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
